rns503_reverse_converter: RTL and testbench
===========================================

Name: rns503_reverse_converter

Overview:
- Residue-to-binary decoder for the two-modulus RNS {503, 512}. It is the inverse of the mod-503 forward conversion tables.
- Accepts a residue pair (r503, r512) and reconstructs the unique integer X in [0, 257535] by two-modulus CRT: X = r512 + 512*t, where t = ((r503 - r512) * 56) mod 503. 56 is the inverse of 512 (which is 9 mod 503), modulo 503.
- The modular multiply is done bit-serially over the constant. The block is multi-cycle with valid/ready handshakes on both sides.
- It sits on the output side of the mod-503 datapath and returns results to binary.

Parameters:
- MOD, 503, odd modulus (fixed for this instance; must be < 512).
- INV_CONST, 56, inverse of 512 modulo MOD.
- INV_BITS, 6, number of bits of INV_CONST processed; also the number of MUL cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input residue pair valid.
- in_ready  out  1  block can accept a pair (high only in IDLE).
- r503  in  9  residue modulo 503; legal range 0..502.
- r512  in  9  residue modulo 512; any value 0..511.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- x  out  18  reconstructed integer 0..257535.
- err  out  1  captured r503 was >= 503.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, x=0, err=0; internal acc/d/count cleared.
  - Reset mid-operation aborts the conversion; no output is produced for it.
- States: IDLE -> PREP -> MUL -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture r503/r512, set err_q = (r503 >= 503), go to PREP.
- PREP (1 cycle):
  - b = r512 >= 503 ? r512-503 : r512.
  - d = r503 >= b ? r503-b : r503+503-b, using 10-bit intermediates.
  - If err_q, force d=0.
  - acc=0, bit index = INV_BITS-1, go to MUL.
- MUL (exactly INV_BITS cycles), processing INV_CONST MSB-first. Each cycle:
  - a2 = 2*acc, minus 503 if >= 503.
  - If the current bit of INV_CONST is set: a2 = a2 + d, minus 503 if >= 503.
  - acc = a2; decrement index.
  - acc stays in 0..502 after every cycle.
  - After the bit-0 cycle, x = r512_q + {acc,9'b0} (18 bits, no overflow); x=0 if err_q. Go to OUT.
- OUT:
  - out_valid=1; x and err are held stable.
  - out_valid must not drop until out_ready=1.
  - On out_valid&out_ready, clear out_valid and go to IDLE.
- Latency: handshake in cycle 0, PREP in cycle 1, MUL in cycles 2..7, out_valid high from cycle 8.
  - With out_ready held high, in_ready returns in cycle 9.
  - Maximum throughput is 1 result per 9 cycles.
- No overlap: in_ready=0 in PREP, MUL and OUT. Inputs changing while not in IDLE are ignored.
- in_valid arriving in the same cycle as the OUT handshake is not accepted; it is taken in the following IDLE cycle.
- out_ready asserted early (before OUT) has no effect.
- x and err change only on the MUL->OUT transition and at reset.

Test Plan:
- Reset with in_valid=1 held: in_ready=1, out_valid=0, x=0, err=0 for every reset cycle; no capture occurs.
- r503=0, r512=0 -> after 8 cycles out_valid=1, x=0, err=0.
- r503=497, r512=488 -> x=1000; r503=5, r512=510 -> x=200702. Both results appear exactly 8 cycles after the handshake.
- r503=502, r512=511 (max) -> x=257535. Hold out_ready=0 for 5 cycles: x and out_valid stay stable and in_ready=0; release gives a single handshake and in_ready=1 on the next cycle.
- r503=503, r512=7 -> err=1, x=0, same 8-cycle latency.
- Random-value soak against the reference model: for a random X in 0..257535, drive (X mod 503, X mod 512) back-to-back; the output must equal X.
- Reset asserted in a MUL cycle: the next cycle is IDLE with out_valid=0, and the next accepted pair converts correctly.

Source files
------------

// File: rtl/rns503_reverse_converter.sv
// Residue-to-binary decoder for the RNS {503, 512}: X = r512 + 512*(((r503-r512)*56) mod 503).
// The constant multiply runs bit-serially, MSB first, one bit per cycle, with valid/ready handshakes on both sides.
module rns503_reverse_converter #(
  parameter int unsigned MOD       = 503,
  parameter int unsigned INV_CONST = 56,
  parameter int unsigned INV_BITS  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  r503,
  input  logic [8:0]  r512,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] x,
  output logic        err
);

  localparam int unsigned IW = (INV_BITS > 1) ? $clog2(INV_BITS) : 1;
  localparam logic [9:0] MOD10 = 10'(MOD);
  localparam logic [INV_BITS-1:0] INV_VEC = INV_BITS'(INV_CONST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic [8:0]    r503_q;
  logic [8:0]    r512_q;
  logic          err_q;
  logic [8:0]    d_q;
  logic [8:0]    acc_q;
  logic [IW-1:0] idx_q;
  logic [17:0]   x_q;
  logic          err_out_q;

  // PREP datapath: d = (r503 - (r512 mod 503)) mod 503
  logic [9:0] r512_e;
  logic [9:0] r503_e;
  logic [9:0] b10;
  logic [9:0] d10;
  logic [8:0] d_calc;

  always_comb begin
    r512_e = {1'b0, r512_q};
    r503_e = {1'b0, r503_q};
    b10    = (r512_e >= MOD10) ? (r512_e - MOD10) : r512_e;
    if (r503_e >= b10) begin
      d10 = r503_e - b10;
    end else begin
      d10 = r503_e + MOD10 - b10;
    end
    d_calc = err_q ? '0 : d10[8:0];
  end

  // MUL datapath: one Horner step acc = 2*acc (+ d) reduced mod 503 after each add
  logic [9:0]  dbl;
  logic [9:0]  dbl_r;
  logic [9:0]  sum;
  logic [9:0]  sum_r;
  logic [8:0]  acc_next;
  logic [17:0] x_calc;
  logic        cur_bit;

  always_comb begin
    cur_bit = INV_VEC[idx_q];
    dbl     = {acc_q, 1'b0};
    dbl_r   = (dbl >= MOD10) ? (dbl - MOD10) : dbl;
    sum     = dbl_r;
    if (cur_bit) begin
      sum = dbl_r + {1'b0, d_q};
    end
    sum_r    = (sum >= MOD10) ? (sum - MOD10) : sum;
    acc_next = sum_r[8:0];
    x_calc   = err_q ? '0 : ({9'b0, r512_q} + {acc_next, 9'b0});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = S_PREP;
        end
      end
      S_PREP: begin
        state_next = S_MUL;
      end
      S_MUL: begin
        if (idx_q == '0) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r503_q    <= '0;
      r512_q    <= '0;
      err_q     <= 1'b0;
      d_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      err_out_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            r503_q <= r503;
            r512_q <= r512;
            err_q  <= ({1'b0, r503} >= MOD10);
          end
        end
        S_PREP: begin
          d_q   <= d_calc;
          acc_q <= '0;
          idx_q <= IW'(INV_BITS - 1);
        end
        S_MUL: begin
          acc_q <= acc_next;
          idx_q <= idx_q - 1'b1;
          if (idx_q == '0) begin
            x_q       <= x_calc;
            err_out_q <= err_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign x   = x_q;
  assign err = err_out_q;

endmodule

// File: tb/tb_rns503_reverse_converter.sv
// Directed and random checks for the {503,512} residue-to-binary converter.
module tb_rns503_reverse_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  r503;
  logic [8:0]  r512;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] x;
  logic        err;

  int checks;
  int failures;

  rns503_reverse_converter #(.MOD(503), .INV_CONST(56), .INV_BITS(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r503      (r503),
    .r512      (r512),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [8:0]  b;
    logic [17:0] exp_x;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge right after the handshake edge.
  task automatic start(input logic [8:0] a, input logic [8:0] b);
    check("start_in_ready", in_ready, 1);
    r503     = a;
    r512     = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r503     = 9'h1ff;
    r512     = 9'h1ff;
  endtask

  // Cycles counted from the handshake cycle (cycle 0) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      failures++;
      $display("FAIL wait_out: out_valid timeout after %0d cycles", lat);
    end
  endtask

  task automatic convert(input string name, input logic [8:0] a, input logic [8:0] b,
                         input logic [17:0] ex, input logic ee, input bit chk_lat);
    int lat;
    start(a, b);
    wait_out(lat);
    if (chk_lat) check({name, "_latency"}, lat, 8);
    check({name, "_x"}, x, ex);
    check({name, "_err"}, err, ee);
    @(negedge clk);
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_out_valid_after"}, out_valid, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    logic [17:0] xs;
    logic [17:0] rx;
    checks    = 0;
    failures  = 0;
    vecs[0] = '{9'd0,   9'd0,   18'd0,      1'b0};
    vecs[1] = '{9'd497, 9'd488, 18'd1000,   1'b0};
    vecs[2] = '{9'd5,   9'd510, 18'd200702, 1'b0};
    vecs[3] = '{9'd502, 9'd511, 18'd257535, 1'b0};
    vecs[4] = '{9'd503, 9'd7,   18'd0,      1'b1};
    vecs[5] = '{9'd0,   9'd1,   18'd228865, 1'b0};
    vecs[6] = '{9'd511, 9'd0,   18'd0,      1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    r503      = 9'd5;
    r512      = 9'd510;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_x", x, 0);
      check("rst_err", err, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_x, vecs[i].exp_err, 1'b1);
    end

    // Backpressure on max value, with a new pair offered during the OUT handshake.
    out_ready = 1'b0;
    start(9'd502, 9'd511);
    wait_out(lat);
    check("bp_latency", lat, 8);
    xs = x;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_x_stable", x, 257535);
      check("bp_in_ready", in_ready, 0);
    end
    check("bp_x_held", x, xs);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    r503      = 9'd497;
    r512      = 9'd488;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovl_taken_in_idle", in_ready, 0);
    wait_out(lat);
    check("ovl_latency", lat, 8);
    check("ovl_x", x, 1000);
    @(negedge clk);

    // Random soak, back-to-back with out_ready held high.
    for (int i = 0; i < 20; i++) begin
      rx = 18'($urandom_range(257535, 0));
      convert("soak", 9'(rx % 503), 9'(rx % 512), rx, 1'b0, 1'b0);
    end

    // Reset in the middle of MUL aborts the conversion.
    start(9'd1, 9'd2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_x", x, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_output", out_valid, 0);
    end
    convert("midrst_next", 9'd5, 9'd510, 18'd200702, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
